adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one combinational prefix adder (Sklansky, Kogge-Stone, etc., instanced outside this block) among NREQ requesters.
- Round-robin arbitration of operand requests; two registered pipeline stages around the adder, mirroring the registered-input/registered-output timing of the adder wrappers.
- Valid/ready handshake on each request port and on the single response port.
- Each response carries the requester ID.

Parameters:
- WIDTH, 16, operand/sum width; must match the attached adder.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester-ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- add_a  out  WIDTH  operand A to the shared adder
- add_b  out  WIDTH  operand B to the shared adder
- add_sum  in  WIDTH  sum from the shared adder
- add_cout  in  1  carry-out from the shared adder
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester that issued the operands
- rsp_sum  out  WIDTH  registered sum
- rsp_cout  out  1  registered carry-out
- busy  out  1  op_valid | rsp_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Single clock domain (clk); rst asserts asynchronously and deasserts synchronously to clk externally.
- Reset values:
  - op_valid=0, op_id=0, add_a=0, add_b=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - Priority pointer ptr=0.
- Reset mid-operation: all in-flight operations are discarded with no response. ptr returns to 0.
- Stage 1 (operand regs op_a, op_b, op_id, op_valid):
  - add_a=op_a and add_b=op_b directly from flops.
  - Held stable while stalled; hold last value when op_valid=0.
- Stage 2 (response regs rsp_*).
- Advance rules:
  - s2_load = op_valid & (!rsp_valid | rsp_ready).
  - s1_free = !op_valid | s2_load.
  - On s2_load: rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_id<=op_id, rsp_valid<=1.
  - Else if rsp_ready: rsp_valid<=0.
- Arbitration (combinational):
  - grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[grant] = s1_free & |req_valid. All other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] & req_ready[g]):
  - op_a<=req_a[g], op_b<=req_b[g], op_id<=g, op_valid<=1, ptr<=(g+1) mod NREQ.
- No accept and s2_load: op_valid<=0. ptr is unchanged when nothing is accepted.
- Latency and throughput:
  - Accept at edge t gives rsp_valid=1 after edge t+1, i.e. 2 cycles with rsp_ready held high.
  - Throughput is 1 operation per cycle.
- Backpressure:
  - rsp_valid & !rsp_ready with op_valid=1 makes both stages hold and all req_ready=0.
  - At most 2 operations in flight.
- Arithmetic:
  - Sum is modulo 2^WIDTH; carry is reported on rsp_cout. The block never alters the sum.
- Ordering: responses return in accept order. No reordering, no drops except at reset.
- Fairness: a continuously asserting requester waits at most NREQ-1 accepts between its own.
- Unused requester inputs are ignored when their req_valid=0.

Test Plan:
- Single request: req0 a=0x1234, b=0x0001, rsp_ready=1 -> req_ready[0]=1 in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=0x1235, rsp_cout=0.
- All four valid from reset (ptr=0), operands a=i, b=0x10*i:
  - Accepts occur on consecutive cycles in order 0, 1, 2, 3.
  - Responses arrive back-to-back with ids 0, 1, 2, 3 and sums 0x00, 0x11, 0x22, 0x33.
- Carry wrap: a=0xFFFF, b=0x0001 -> rsp_sum=0x0000, rsp_cout=1. Then a=0x8000, b=0x8000 -> rsp_sum=0x0000, rsp_cout=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles with req1 streaming.
  - Exactly 2 accepts occur, then req_ready=0 and rsp_* stays stable.
  - On release, responses drain in order with no loss or duplication.
- Fairness: req0 and req2 held valid continuously for 8 accepts -> grant sequence 0, 2, 0, 2, ...; req0 is never granted twice in a row.
- Reset mid-flight: assert rst with op_valid=1 and rsp_valid=1 -> both are 0 immediately (asynchronously), add_a=0, ptr=0, and no stale response appears after release.

Source files
------------

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin sharing of one external combinational adder among
//               NREQ requesters, with registered operand and response stages.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IDW-1:0]   r_op_id;
    logic             r_op_valid;
    logic [IDW-1:0]   r_ptr;

    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;

    logic             w_s2_load;
    logic             w_s1_free;
    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_ptr_next;
    logic             w_accept;
    int               w_idx;

    assign w_s2_load = r_op_valid & (~r_rsp_valid | rsp_ready);
    assign w_s1_free = ~r_op_valid | w_s2_load;

    // First valid requester at or after the priority pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = IDW'(w_idx);
            end
        end
    end

    assign w_accept   = w_found & w_s1_free;
    assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= '0;
            r_op_valid <= 1'b0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_op_a     <= req_a[int'(w_grant)*WIDTH +: WIDTH];
            r_op_b     <= req_b[int'(w_grant)*WIDTH +: WIDTH];
            r_op_id    <= w_grant;
            r_op_valid <= 1'b1;
            r_ptr      <= w_ptr_next;
        end else if (w_s2_load) begin
            r_op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else if (w_s2_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_op_id;
            r_rsp_sum   <= add_sum;
            r_rsp_cout  <= add_cout;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign busy      = r_op_valid | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arbiter
// Description : Directed self-checking bench for adder_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    int n_checks;
    int n_errors;
    int n_accepts;

    adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    // Stand-in for the external shared adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_single(input string tag, input int idx, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_sum,
                             input logic exp_cout);
        rsp_ready = 1'b1;
        set_op(idx, a, b);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid = '0;
        check({tag, "_lat"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(idx));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        tick();
        check({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_accepts = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);

        do_single("single", 0, 16'h1234, 16'h0001, 16'h1235, 1'b0);

        // All four valid from ptr=0: grants 0..3 on consecutive cycles.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i), 16'(16 * i));
        req_valid = 4'b1111;
        for (int c = 0; c <= NREQ; c++) begin
            if (c == NREQ) req_valid = '0;
            #1;
            if (c < NREQ) check("rr_ready", 32'(req_ready), 32'(1 << c));
            tick();
            if (c >= 1) begin
                check("rr_valid", 32'(rsp_valid), 32'd1);
                check("rr_id", 32'(rsp_id), 32'(c - 1));
                check("rr_sum", 32'(rsp_sum), 32'(17 * (c - 1)));
            end
        end
        tick();
        check("rr_drain", 32'(rsp_valid), 32'd0);

        do_single("wrap1", 2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        do_single("wrap2", 3, 16'h8000, 16'h8000, 16'h0000, 1'b1);

        // Backpressure with requester 1 streaming.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        n_accepts = 0;
        for (int c = 0; c < 5; c++) begin
            set_op(1, 16'(16'h0100 + n_accepts), 16'h0000);
            #1;
            if (c >= 2) check("bp_ready", 32'(req_ready), 32'd0);
            if (req_ready[1]) n_accepts++;
            tick();
            if (c >= 2) begin
                check("bp_hold_valid", 32'(rsp_valid), 32'd1);
                check("bp_hold_sum", 32'(rsp_sum), 32'h0100);
            end
        end
        check("bp_accepts", 32'(n_accepts), 32'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("bp_d0_sum", 32'(rsp_sum), 32'h0100);
        tick();
        check("bp_d1_valid", 32'(rsp_valid), 32'd1);
        check("bp_d1_id", 32'(rsp_id), 32'd1);
        check("bp_d1_sum", 32'(rsp_sum), 32'h0101);
        tick();
        check("bp_d2_valid", 32'(rsp_valid), 32'd0);

        // Fairness between requesters 0 and 2.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("fair_grant", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        check("fair_idle", 32'(busy), 32'd0);

        // Reset with both stages occupied.
        rsp_ready = 1'b0;
        set_op(3, 16'h0005, 16'h0005);
        set_op(0, 16'h0007, 16'h0001);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        check("mid_busy_pre", 32'({rsp_valid, busy}), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_add_a", 32'(add_a), 32'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_stale", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b0011;
        #1;
        check("mid_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
